jtpinpon_objline: RTL and testbench
===================================

# jtpinpon_objline

Object draw engine and double line buffer for the Pinpon sprite path, directly downstream of the object table scanner. It accepts one object at a time (code, x position, palette, flips, row within the sprite) and fetches the 16-pixel, 2bpp row from SDRAM. Each pixel is mapped through the 256x4 object colour PROM and non-transparent pixels are written into the line buffer being built. The other buffer bank is read out, and cleared behind the read, at pixel rate as the 4-bit object colour for the mixer.

## Interface
- HOFFSET, 8'd6: subtracted from hdump[7:0] to form the readout address.
- clk  in  1  48 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- pxl_cen  in  1  pixel clock enable, readout side.
- cen2  in  1  clk/2 enable; all draw-side state advances only on cen2.
- LHBL  in  1  active-low horizontal blank.
- hinit_x  in  1  line start, stretched to cover one cen2.
- hdump  in  9  horizontal dump counter.
- draw  in  1  start pulse, one cen2 long; sampled only when busy=0.
- busy  out  1  engine occupied.
- code  in  8  sprite code.
- xpos  in  8  left pixel column.
- pal  in  5  palette.
- hflip  in  1  horizontal flip.
- vflip  in  1  vertical flip.
- ysub  in  4  row inside the sprite.
- prog_data  in  4  PROM load data.
- prog_addr  in  8  PROM load address.
- prog_en  in  1  PROM write strobe.
- rom_addr  out  12  {code, row}.
- rom_data  in  32  one sprite row.
- rom_cs  out  1  SDRAM request.
- rom_ok  in  1  data valid.
- pxl  out  4  object colour; 0 means transparent.

## Operation
- row = vflip ? ~ysub : ysub. rom_addr = {code, row}, latched when draw is accepted.
- Pixel n (0..15, left to right) = {rom_data[n+16], rom_data[n]}. With hflip, screen column n uses pixel 15-n.
- PROM address = {1'b0, pal, pix}. The PROM is a 256x4 RAM, written by prog_en at prog_addr, with a synchronous 1-clk read.
- Transparency: a PROM output of 0 is not written to the buffer.
- Buffer write address = xpos + n, 9-bit sum. Writes with carry (sum > 255) are dropped, so there is no wrap.
- Priority: a later write to the same column overwrites an earlier one.
- Line buffer: two banks of 256x4. Bank select `wbank` toggles on every cen2 with hinit_x high. Draw writes go to `wbank`; readout uses `~wbank`.
- Draw FSM, advanced on cen2:
  - IDLE: when draw=1, latch inputs, set busy=1 and rom_cs=1, go to WAIT.
  - WAIT: accept rom_data on the first cen2 with rom_ok=1 that is not the first cen2 in WAIT, because rom_ok may be stale from a previous address. On acceptance, latch data, set rom_cs=0, n=0, go to PIX.
  - PIX: present pixel n to the PROM, then write on the following cen2. After n=15 has been written, go to IDLE and set busy=0.
- Readout: on each pxl_cen, addr = hdump[7:0] - HOFFSET (8-bit wrap). pxl <= LHBL ? buf[~wbank][addr] : 0. The location is then written with 0 on the next clk, so the bank is empty for reuse. When LHBL=0, nothing is read and nothing is cleared.
- hinit_x while busy: abort. FSM goes to IDLE, busy=0, rom_cs=0, and the bank still toggles.

## Timing
- Reset values:
  - busy=0, rom_cs=0, rom_addr=0, pxl=0, wbank=0, FSM IDLE.
  - Buffer and PROM contents are not reset.
- busy rises on the cen2 that accepts draw. A draw pulse while busy=1 is ignored.
- Minimum object time with rom_ok held high: accept draw, at least 2 cen2 in WAIT, 16 PIX writes plus 1 PROM-latency slot. That is 20 cen2 from draw to busy=0.
- Readout latency: pxl is valid 1 clk after pxl_cen. The clear write happens on the clk after the read and never collides with a draw write, because the two sides use opposite banks.
- If prog_en is active during the display, PROM reads may return the value being written; no hazard protection is required.

## Test plan
- Basic draw: PROM[k]=k. code=8'h12, ysub=3, pal=5, xpos=40, rom_data=32'h0000_FFFF, no flip. Expect rom_addr=12'h123, busy for 20 cen2. After a hinit_x swap, columns 40..55 read 4'd5 ({0,5,1}→PROM addr 21→value 5), all other columns 0, and a second read of a column returns 0.
- Flips: vflip with ysub=3 gives rom_addr low nibble 12. With hflip and rom_data=32'h0000_0001, only column xpos+15 is non-zero.
- Right-edge clip: xpos=250 with all pixels opaque. Columns 250..255 are written; column 0..9 are untouched.
- Overlap and transparency: object A at x=10 all colour 3, then object B at x=14 whose pixels are 0 except pixel 2. Expect column 16 = B colour, columns 10..25 otherwise A colour.
- Handshake: hold rom_ok high before the request → the data is not taken on the first WAIT cen2. A draw pulse during busy is ignored. hinit_x mid-PIX → busy=0 and rom_cs=0 on that cen2.
- Reset mid-draw: assert rst during WAIT → busy=0, rom_cs=0, pxl=0 immediately; after release, a new draw proceeds normally.

Source files
------------

// File: rtl/jtpinpon_objline.sv
// Pinpon object draw engine and double line buffer.
// One object at a time: fetch its 16-pixel 2bpp row, map each pixel through
// the object colour PROM and paint the opaque ones into the bank being built.
// The opposite bank is read out at pixel rate and wiped behind the read.
module jtpinpon_objline #(
  parameter logic [7:0] HOFFSET = 8'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        LHBL,
  input  logic        hinit_x,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [7:0]  code,
  input  logic [7:0]  xpos,
  input  logic [4:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic [11:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        rom_cs,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_PIX  = 2'd2;

  // draw-side control
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        accept, take, present, wr_pix;
  logic [11:0] rom_addr_q;
  logic        wbank_q;

  // latched object attributes and row data
  logic [7:0]  xpos_q;
  logic [4:0]  pal_q;
  logic        hflip_q;
  logic [31:0] data_q;
  logic [3:0]  idx;
  logic [1:0]  pix;

  // pixel pipeline: p0 = PROM address presented, p1 = PROM output
  logic [7:0]  prom_addr_p0;
  logic [8:0]  col_p0;
  logic        vld_p0;
  logic [3:0]  prom_q_p1;
  logic        draw_we;

  logic [3:0]  prom  [0:255];
  logic [3:0]  lbuf0 [0:255];
  logic [3:0]  lbuf1 [0:255];

  // readout side
  logic [7:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        clr_pend_q;
  logic [7:0]  clr_addr_q;
  logic        clr_bank_q;
  logic [3:0]  pxl_q;

  logic        unused_hdump;
  assign unused_hdump = hdump[8];

  assign busy     = (state_q != ST_IDLE);
  assign rom_cs   = (state_q == ST_WAIT);
  assign rom_addr = rom_addr_q;
  assign pxl      = pxl_q;

  // Column n shows pixel 15-n when flipped; bit n is the low plane, n+16 the high.
  assign idx = hflip_q ? (4'd15 - cnt_q[3:0]) : cnt_q[3:0];
  assign pix = {data_q[{1'b1, idx}], data_q[{1'b0, idx}]};

  // Draw FSM next state; a line start always wins and aborts the object.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    accept  = 1'b0;
    take    = 1'b0;
    present = 1'b0;
    wr_pix  = 1'b0;
    if (cen2) begin
      if (hinit_x) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (draw) begin
              accept  = 1'b1;
              first_d = 1'b1;
              state_d = ST_WAIT;
            end
          end
          ST_WAIT: begin
            // rom_ok on the first WAIT slot may belong to the previous address
            first_d = 1'b0;
            if (rom_ok && !first_q) begin
              take    = 1'b1;
              cnt_d   = 5'd0;
              state_d = ST_PIX;
            end
          end
          ST_PIX: begin
            wr_pix = vld_p0;
            if (cnt_q == 5'd16) begin
              state_d = ST_IDLE;
            end else begin
              present = 1'b1;
              cnt_d   = cnt_q + 5'd1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Draw control registers and bank select, advanced on cen2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      first_q    <= 1'b0;
      rom_addr_q <= 12'd0;
      vld_p0     <= 1'b0;
      wbank_q    <= 1'b0;
    end else if (cen2) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      vld_p0  <= present;
      if (accept) rom_addr_q <= {code, vflip ? ~ysub : ysub};
      if (hinit_x) wbank_q <= ~wbank_q;
    end
  end

  // Object attributes, row data and the p0 pipeline stage.
  always_ff @(posedge clk) begin
    if (cen2) begin
      if (accept) begin
        xpos_q  <= xpos;
        pal_q   <= pal;
        hflip_q <= hflip;
      end
      if (take) data_q <= rom_data;
      if (present) begin
        prom_addr_p0 <= {1'b0, pal_q, pix};
        col_p0       <= {1'b0, xpos_q} + {5'd0, cnt_q[3:0]};
      end
    end
  end

  // --- p0 -> p1: colour PROM, loadable, synchronous read ---
  always_ff @(posedge clk) begin
    if (prog_en) prom[prog_addr] <= prog_data;
    prom_q_p1 <= prom[prom_addr_p0];
  end

  // --- p1 -> line buffer: drop transparent pixels and columns past 255 ---
  assign draw_we = wr_pix && !col_p0[8] && (prom_q_p1 != 4'd0);

  // Each bank takes either the draw write or the readout clear.
  always_ff @(posedge clk) begin
    if (draw_we && !wbank_q)
      lbuf0[col_p0[7:0]] <= prom_q_p1;
    else if (clr_pend_q && !clr_bank_q)
      lbuf0[clr_addr_q] <= 4'd0;
    if (draw_we && wbank_q)
      lbuf1[col_p0[7:0]] <= prom_q_p1;
    else if (clr_pend_q && clr_bank_q)
      lbuf1[clr_addr_q] <= 4'd0;
  end

  assign rd_addr = hdump[7:0] - HOFFSET;
  assign rd_data = wbank_q ? lbuf0[rd_addr] : lbuf1[rd_addr];

  // Readout of the idle bank; a visible read schedules a clear on the next clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl_q      <= 4'd0;
      clr_pend_q <= 1'b0;
    end else begin
      clr_pend_q <= pxl_cen & LHBL;
      if (pxl_cen) pxl_q <= LHBL ? rd_data : 4'd0;
    end
  end

  // Remember where the clear must land, even if the banks swap meanwhile.
  always_ff @(posedge clk) begin
    if (pxl_cen) begin
      clr_addr_q <= rd_addr;
      clr_bank_q <= ~wbank_q;
    end
  end

endmodule

// File: tb/tb_jtpinpon_objline.sv
// Bench for jtpinpon_objline: directed objects, line-level model of the two
// banks, and a readout checker that compares every visible pixel.
module tb_jtpinpon_objline;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, cen2, LHBL, hinit_x;
  logic [8:0]  hdump;
  logic        draw, busy;
  logic [7:0]  code, xpos;
  logic [4:0]  pal;
  logic        hflip, vflip;
  logic [3:0]  ysub;
  logic [3:0]  prog_data;
  logic [7:0]  prog_addr;
  logic        prog_en;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_cs, rom_ok;
  logic [3:0]  pxl;

  int checks = 0;
  int errors = 0;

  logic [3:0] mprom [0:255];
  logic [3:0] mbank [0:1][0:255];
  bit         mwbank;
  bit         scrub;

  jtpinpon_objline dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cen2(cen2), .LHBL(LHBL),
    .hinit_x(hinit_x), .hdump(hdump), .draw(draw), .busy(busy),
    .code(code), .xpos(xpos), .pal(pal), .hflip(hflip), .vflip(vflip),
    .ysub(ysub), .prog_data(prog_data), .prog_addr(prog_addr),
    .prog_en(prog_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .pxl(pxl)
  );

  always #5 clk = ~clk;

  initial begin
    cen2 = 1'b0;
    forever @(negedge clk) cen2 = ~cen2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // advance to just after the next clk edge that has cen2 high
  task automatic step_cen2();
    @(posedge clk);
    while (!cen2) @(posedge clk);
    #1;
  endtask

  // paint one finished object into the bank being built
  task automatic model_obj(input logic [7:0] x, input logic [4:0] p,
                           input bit hf, input logic [31:0] d);
    int idx, col;
    logic [1:0] px;
    logic [3:0] c;
    for (int n = 0; n < 16; n++) begin
      idx = hf ? 15 - n : n;
      px  = {d[idx+16], d[idx]};
      c   = mprom[{1'b0, p, px}];
      col = int'(x) + n;
      if (col < 256 && c != 4'd0) mbank[mwbank][col] = c;
    end
  endtask

  // readout checker: every pxl_cen clk, predict the pixel from the model
  initial begin
    logic [7:0] a;
    logic [3:0] e;
    forever begin
      @(posedge clk);
      if (pxl_cen && !rst) begin
        a = hdump[7:0] - 8'd6;
        if (LHBL) begin
          e = mbank[~mwbank][a];
          mbank[~mwbank][a] = 4'd0;
        end else begin
          e = 4'd0;
        end
        #1;
        if (!scrub) chk("pxl_model", 32'(pxl), 32'(e));
      end
    end
  end

  task automatic read_col(input logic [7:0] col, input bit lhbl, output logic [3:0] v);
    @(negedge clk);
    hdump   = {1'b0, 8'(col + 8'd6)};
    LHBL    = lhbl;
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    v = pxl;
    @(negedge clk);
    LHBL = 1'b0;
  endtask

  task automatic read_line();
    logic [3:0] v;
    for (int c = 0; c < 256; c++) read_col(8'(c), 1'b1, v);
  endtask

  task automatic do_hinit();
    step_cen2();
    hinit_x = 1'b1;
    step_cen2();
    hinit_x = 1'b0;
    mwbank  = ~mwbank;
  endtask

  task automatic draw_obj(input logic [7:0] c, input logic [7:0] x, input logic [4:0] p,
                          input bit hf, input bit vf, input logic [3:0] ys,
                          input logic [31:0] d, input int dly, input bit ign,
                          output int steps);
    int take_i;
    logic [11:0] exp_addr;
    take_i   = (dly + 1 > 2) ? dly + 1 : 2;
    exp_addr = {c, vf ? ~ys : ys};
    step_cen2();
    code = c; xpos = x; pal = p; hflip = hf; vflip = vf; ysub = ys;
    draw = 1'b1;
    rom_ok = (dly == 0);
    rom_data = ~d;
    step_cen2();
    draw = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_rom_cs", 32'(rom_cs), 32'd1);
    chk("accept_rom_addr", 32'(rom_addr), 32'(exp_addr));
    code = ~c; xpos = ~x; pal = ~p; hflip = ~hf; vflip = ~vf; ysub = ~ys;
    steps = 0;
    while (busy && steps < 100) begin
      steps++;
      rom_ok   = (steps > dly);
      rom_data = (steps >= take_i) ? d : ~d;
      if (ign && steps == 5) begin
        draw = 1'b1;
        code = 8'hAA;
      end else begin
        draw = 1'b0;
      end
      step_cen2();
      if (steps == take_i - 1) chk("wait_rom_cs", 32'(rom_cs), 32'd1);
      if (steps == take_i) begin
        chk("take_rom_cs", 32'(rom_cs), 32'd0);
        chk("take_busy", 32'(busy), 32'd1);
      end
    end
    rom_ok = 1'b0;
    draw   = 1'b0;
    chk("latency", 32'(steps), 32'(take_i + 17));
    chk("hold_rom_addr", 32'(rom_addr), 32'(exp_addr));
    model_obj(x, p, hf, d);
    step_cen2();
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] v;
    int steps;
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; hinit_x = 1'b0; hdump = 9'd0;
    draw = 1'b0; code = 8'd0; xpos = 8'd0; pal = 5'd0; hflip = 1'b0;
    vflip = 1'b0; ysub = 4'd0; prog_data = 4'd0; prog_addr = 8'd0;
    prog_en = 1'b0; rom_data = 32'd0; rom_ok = 1'b0;
    scrub = 1'b1; mwbank = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 256; c++) mbank[b][c] = 4'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pxl", 32'(pxl), 32'd0);
    @(negedge clk) rst = 1'b0;

    // colour PROM holds its own address (low nibble)
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      prog_en = 1'b1; prog_addr = 8'(k); prog_data = 4'(k);
      mprom[k] = 4'(k);
    end
    @(negedge clk) prog_en = 1'b0;

    // wipe both banks through the readout path
    read_line();
    do_hinit();
    read_line();
    scrub = 1'b0;

    // basic object, rom_ok already high before the request
    draw_obj(8'h12, 8'd40, 5'd5, 1'b0, 1'b0, 4'd3, 32'h0000_FFFF, 0, 1'b0, steps);
    chk("basic_latency_lit", 32'(steps + 1), 32'd20);
    chk("basic_rom_addr_lit", 32'(rom_addr), 32'h123);
    do_hinit();
    read_col(8'd41, 1'b1, v); chk("basic_col41", 32'(v), 32'd5);
    read_col(8'd40, 1'b0, v); chk("lhbl_low", 32'(v), 32'd0);
    read_col(8'd40, 1'b1, v); chk("basic_col40", 32'(v), 32'd5);
    read_col(8'd40, 1'b1, v); chk("reread_cleared", 32'(v), 32'd0);
    read_col(8'd55, 1'b1, v); chk("basic_col55", 32'(v), 32'd5);
    read_col(8'd56, 1'b1, v); chk("basic_col56", 32'(v), 32'd0);
    read_col(8'd39, 1'b1, v); chk("basic_col39", 32'(v), 32'd0);
    read_line();

    // flips, late rom_ok, and a draw pulse while busy
    draw_obj(8'h12, 8'd100, 5'd4, 1'b1, 1'b1, 4'd3, 32'h0000_0001, 2, 1'b1, steps);
    chk("flip_rom_addr_lit", 32'(rom_addr), 32'h12C);
    chk("late_latency_lit", 32'(steps + 1), 32'd21);
    do_hinit();
    read_col(8'd115, 1'b1, v); chk("hflip_col115", 32'(v), 32'd1);
    read_col(8'd100, 1'b1, v); chk("hflip_col100", 32'(v), 32'd0);
    read_line();

    // right-edge clip, then overlap with a mostly transparent object
    draw_obj(8'h01, 8'd250, 5'd0, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 0, 1'b0, steps);
    draw_obj(8'h02, 8'd10, 5'd0, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 0, 1'b0, steps);
    draw_obj(8'h03, 8'd14, 5'd4, 1'b0, 1'b0, 4'd0, 32'h0004_0000, 0, 1'b0, steps);
    do_hinit();
    read_col(8'd16, 1'b1, v);  chk("overlap_col16", 32'(v), 32'd2);
    read_col(8'd15, 1'b1, v);  chk("overlap_col15", 32'(v), 32'd3);
    read_col(8'd25, 1'b1, v);  chk("overlap_col25", 32'(v), 32'd3);
    read_col(8'd255, 1'b1, v); chk("edge_col255", 32'(v), 32'd3);
    read_col(8'd0, 1'b1, v);   chk("edge_col0", 32'(v), 32'd0);
    read_col(8'd9, 1'b1, v);   chk("edge_col9", 32'(v), 32'd0);
    read_line();

    // abort mid-PIX with a line start (object is fully transparent)
    step_cen2();
    code = 8'h07; xpos = 8'd80; pal = 5'd0; hflip = 1'b0; vflip = 1'b0;
    ysub = 4'd0; rom_data = 32'd0; rom_ok = 1'b1; draw = 1'b1;
    step_cen2();
    draw = 1'b0;
    repeat (5) step_cen2();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    hinit_x = 1'b1;
    step_cen2();
    hinit_x = 1'b0;
    mwbank  = ~mwbank;
    rom_ok  = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rom_cs", 32'(rom_cs), 32'd0);
    step_cen2();
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // reset in the middle of WAIT
    draw_obj(8'h33, 8'd60, 5'd5, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 0, 1'b0, steps);
    do_hinit();
    read_col(8'd60, 1'b1, v); chk("pre_rst_pxl", 32'(v), 32'd7);
    step_cen2();
    code = 8'h55; xpos = 8'd0; pal = 5'd5; rom_ok = 1'b0; draw = 1'b1;
    step_cen2();
    draw = 1'b0;
    step_cen2();
    chk("rst_wait_rom_cs", 32'(rom_cs), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rom_cs", 32'(rom_cs), 32'd0);
    chk("midrst_pxl", 32'(pxl), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    mwbank = 1'b0;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    draw_obj(8'h44, 8'd200, 5'd5, 1'b0, 1'b0, 4'd0, 32'h0000_FFFF, 0, 1'b0, steps);
    chk("post_rst_latency_lit", 32'(steps + 1), 32'd20);
    do_hinit();
    read_col(8'd200, 1'b1, v); chk("post_rst_col200", 32'(v), 32'd5);
    read_line();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
